mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage in the 16-bit core.
- Consumes the execute stage's ALU result, store data, opcode and destination register.
- Performs LW/SW through a ready-handshaked data-memory port and registers the write-back bundle for the WB stage.
- Stalls upstream while a memory access is outstanding and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/mem_stage_if.sv | 38 +++
 rtl/mem_stage.sv | 84 ++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Execute-to-WB bundle, data-memory port and status signals of the memory stage.
interface mem_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
);
  logic          in_valid;
  logic [15:0]   instr;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] store_data;
  logic [RW-1:0] reg_dst;
  logic          reg_write;
  logic          stall;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [RW-1:0] wb_dst;
  logic          wb_we;
  logic [15:0]   stall_cnt;

  modport master (
    output in_valid, instr, alu_result, store_data, reg_dst, reg_write,
    output mem_rdata, mem_rdy,
    input  stall, mem_addr, mem_wdata, mem_re, mem_we,
    input  wb_valid, wb_data, wb_dst, wb_we, stall_cnt
  );

  modport slave (
    input  in_valid, instr, alu_result, store_data, reg_dst, reg_write,
    input  mem_rdata, mem_rdy,
    output stall, mem_addr, mem_wdata, mem_re, mem_we,
    output wb_valid, wb_data, wb_dst, wb_we, stall_cnt
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues LW/SW over a ready-handshaked port, registers the
// write-back bundle and counts stall cycles (saturating).
module mem_stage #(
  parameter int unsigned DW    = 16,
  parameter int unsigned RW    = 4,
  parameter logic [3:0]  OP_LW = 4'b1000,
  parameter logic [3:0]  OP_SW = 4'b1001
) (
  input logic        clk,
  input logic        rst,
  mem_stage_if.slave bus
);
  typedef enum logic {IDLE, BUSY} stateT;

  stateT         state;
  logic [RW-1:0] pendDst;
  logic          pendWe;
  logic [3:0]    opcode;
  logic          unusedInstr;

  assign opcode      = bus.instr[15:12];
  assign unusedInstr = ^bus.instr[11:0];
  assign bus.stall   = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pendDst       <= '0;
      pendWe        <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.wb_valid  <= 1'b0;
      bus.wb_data   <= '0;
      bus.wb_dst    <= '0;
      bus.wb_we     <= 1'b0;
      bus.stall_cnt <= '0;
    end else begin
      bus.wb_valid <= 1'b0;
      if (state == BUSY && bus.stall_cnt != '1)
        bus.stall_cnt <= bus.stall_cnt + 16'd1;

      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (opcode == OP_LW) begin
              bus.mem_addr <= bus.alu_result;
              bus.mem_re   <= 1'b1;
              pendDst      <= bus.reg_dst;
              pendWe       <= bus.reg_write;
              state        <= BUSY;
            end else if (opcode == OP_SW) begin
              bus.mem_addr  <= bus.alu_result;
              bus.mem_wdata <= bus.store_data;
              bus.mem_we    <= 1'b1;
              pendDst       <= bus.reg_dst;
              pendWe        <= 1'b0;
              state         <= BUSY;
            end else begin
              bus.wb_valid <= 1'b1;
              bus.wb_data  <= bus.alu_result;
              bus.wb_dst   <= bus.reg_dst;
              bus.wb_we    <= bus.reg_write;
            end
          end
        end
        BUSY: begin
          if (bus.mem_rdy) begin
            // mem_re still distinguishes a load from a store on the completing edge
            bus.wb_data  <= bus.mem_re ? bus.mem_rdata : bus.mem_addr;
            bus.wb_dst   <= pendDst;
            bus.wb_we    <= pendWe;
            bus.wb_valid <= 1'b1;
            bus.mem_re   <= 1'b0;
            bus.mem_we   <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus random transactions checked against
// a transaction-level model with its own data memory and stall-cycle tally.
module tb_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   expCnt = 0;
  logic [15:0] memArr [0:255];

  mem_stage_if #(.DW(16), .RW(4)) bus ();

  mem_stage #(.DW(16), .RW(4), .OP_LW(4'b1000), .OP_SW(4'b1001)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst && bus.stall === 1'b0) ; // model count updated by callers
  endtask

  task automatic bumpCnt();
    if (expCnt < 16'hFFFF) expCnt++;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.mem_rdy  = 1'b0;
  endtask

  // One instruction from presentation to write-back, with 'waits' not-ready BUSY cycles.
  task automatic doTxn(input logic [3:0] op, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [3:0] dst, input logic rw, input int waits);
    bit isLd, isSt;
    logic [15:0] expWb;
    isLd = (op == 4'b1000);
    isSt = (op == 4'b1001);
    bus.in_valid   = 1'b1;
    bus.instr      = {op, 12'($urandom)};
    bus.alu_result = alu;
    bus.store_data = sd;
    bus.reg_dst    = dst;
    bus.reg_write  = rw;
    tick();
    idle();
    bus.instr = '0;
    if (!isLd && !isSt) begin
      chk("alu_wb_valid", bus.wb_valid, 1);
      chk("alu_wb_data", bus.wb_data, alu);
      chk("alu_wb_dst", bus.wb_dst, dst);
      chk("alu_wb_we", bus.wb_we, rw);
      chk("alu_stall", bus.stall, 0);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        chk("mem_stall", bus.stall, 1);
        chk("mem_addr", bus.mem_addr, alu);
        chk("mem_re", bus.mem_re, isLd);
        chk("mem_we", bus.mem_we, isSt);
        chk("mem_wb_idle", bus.wb_valid, 0);
        if (isSt) chk("mem_wdata", bus.mem_wdata, sd);
        bus.mem_rdy   = (k == waits);
        bus.mem_rdata = isLd ? memArr[alu[7:0]] : 16'($urandom);
        tick();
        bumpCnt();
      end
      bus.mem_rdy = 1'b0;
      expWb = isLd ? memArr[alu[7:0]] : alu;
      if (isSt) memArr[alu[7:0]] = sd;
      chk("mem_wb_valid", bus.wb_valid, 1);
      chk("mem_wb_data", bus.wb_data, expWb);
      chk("mem_wb_we", bus.wb_we, isLd ? rw : 1'b0);
      if (isLd) chk("mem_wb_dst", bus.wb_dst, dst);
      chk("mem_done_stall", bus.stall, 0);
      chk("mem_done_re", bus.mem_re, 0);
      chk("mem_done_we", bus.mem_we, 0);
    end
    chk("stall_cnt", bus.stall_cnt, expCnt);
  endtask

  initial begin
    logic [3:0] ops [4];
    ops[0] = 4'b0000; ops[1] = 4'b1000; ops[2] = 4'b1001; ops[3] = 4'b0101;
    for (int i = 0; i < 256; i++) memArr[i] = 16'($urandom);
    idle();
    bus.instr = '0; bus.alu_result = '0; bus.store_data = '0;
    bus.reg_dst = '0; bus.reg_write = 1'b0; bus.mem_rdata = '0;

    // Reset state
    #12;
    chk("rst_stall", bus.stall, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Reset while a load is outstanding
    bus.in_valid = 1'b1; bus.instr = 16'h8000; bus.alu_result = 16'h0040;
    bus.reg_dst = 4'd2; bus.reg_write = 1'b1;
    tick();
    idle();
    chk("midrst_pre_re", bus.mem_re, 1);
    chk("midrst_pre_stall", bus.stall, 1);
    rst = 1'b1;
    #1;
    chk("midrst_re", bus.mem_re, 0);
    chk("midrst_stall", bus.stall, 0);
    chk("midrst_cnt", bus.stall_cnt, 0);
    expCnt = 0;
    #2;
    rst = 1'b0;
    bus.mem_rdy = 1'b1;
    tick();
    chk("midrst_no_wb", bus.wb_valid, 0);
    tick();
    chk("idle_rdy_ignored", bus.wb_valid, 0);
    chk("idle_rdy_stall", bus.stall, 0);
    idle();

    // Plain ALU op
    doTxn(4'b0000, 16'h1234, 16'h0000, 4'd3, 1'b1, 0);
    tick();
    chk("add_pulse_end", bus.wb_valid, 0);
    chk("add_hold_data", bus.wb_data, 16'h1234);

    // Load with three not-ready cycles
    memArr[8'hA0] = 16'hBEEF;
    doTxn(4'b1000, 16'h00A0, 16'h0000, 4'd5, 1'b1, 3);
    chk("lw_cnt4", bus.stall_cnt, 4);

    // Single-cycle store
    doTxn(4'b1001, 16'h0010, 16'h5A5A, 4'd7, 1'b1, 0);

    // ADD held during a load stall: accepted only after completion, once
    bus.in_valid = 1'b1; bus.instr = 16'h8000; bus.alu_result = 16'h0010;
    bus.reg_dst = 4'd9; bus.reg_write = 1'b1;
    tick();
    bus.instr = 16'h0000; bus.alu_result = 16'h4321; bus.reg_dst = 4'd4;
    chk("b2b_stall", bus.stall, 1);
    tick(); bumpCnt();
    chk("b2b_ignored", bus.wb_valid, 0);
    bus.mem_rdy = 1'b1; bus.mem_rdata = memArr[8'h10];
    tick(); bumpCnt();
    bus.mem_rdy = 1'b0;
    chk("b2b_lw_valid", bus.wb_valid, 1);
    chk("b2b_lw_data", bus.wb_data, 16'h5A5A);
    chk("b2b_lw_dst", bus.wb_dst, 9);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b_add_valid", bus.wb_valid, 1);
    chk("b2b_add_data", bus.wb_data, 16'h4321);
    chk("b2b_add_dst", bus.wb_dst, 4);
    tick();
    chk("b2b_no_dup", bus.wb_valid, 0);
    chk("b2b_cnt", bus.stall_cnt, expCnt);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      doTxn(ops[$urandom_range(0, 3)], {8'($urandom), 8'($urandom)}, 16'($urandom),
            4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        tick();
        chk("rnd_gap_idle", bus.wb_valid, 0);
      end
    end

    // Saturation of the stall counter
    bus.in_valid = 1'b1; bus.instr = 16'h8000; bus.alu_result = 16'h0033;
    bus.reg_dst = 4'd1; bus.reg_write = 1'b1;
    tick();
    idle();
    for (int c = 0; c < 65540; c++) begin
      tick(); bumpCnt();
      if (c == 65534 - 10) chk("sat_pre", bus.stall_cnt, expCnt);
    end
    chk("sat_cnt", bus.stall_cnt, 16'hFFFF);
    chk("sat_still_busy", bus.mem_re, 1);
    bus.mem_rdy = 1'b1; bus.mem_rdata = 16'hC0DE;
    tick();
    bus.mem_rdy = 1'b0;
    chk("sat_wb_data", bus.wb_data, 16'hC0DE);
    chk("sat_cnt_final", bus.stall_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
